// File: rtl/alu_pkg.sv
// Shared opcodes, scheduler state encoding and ALU flag bundle for the
// round-robin rotate/compare scheduler.
package alu_pkg;

  localparam logic [3:0] OP_ROL = 4'd0;
  localparam logic [3:0] OP_ROR = 4'd1;
  localparam logic [3:0] OP_MAX = 4'd2;
  localparam logic [3:0] OP_MIN = 4'd3;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StExec = 2'd1,
    StResp = 2'd2
  } state_e;

  typedef struct packed {
    logic carry;
    logic zero;
    logic overflow;
    logic illegal;
  } alu_flags_t;

endpackage

// File: rtl/alu_rot_cmp_core.sv
// Combinational rotate/compare datapath: ROL, ROR, unsigned MAX and MIN,
// with carry/zero/overflow flags and an illegal-opcode indication.
module alu_rot_cmp_core
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic [3:0]       opcode_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic [4:0]       shift_i,
  output logic [WIDTH-1:0] result_o,
  output alu_flags_t       flags_o
);

  localparam int unsigned SW = $clog2(WIDTH);

  logic [SW-1:0]    s;
  logic [SW:0]      rs;
  logic [WIDTH-1:0] rol;
  logic [WIDTH-1:0] ror;
  logic             unused_shift;

  // WIDTH is a power of two, so shift mod WIDTH is just the low bits.
  assign s            = shift_i[SW-1:0];
  assign unused_shift = ^shift_i;
  // Complementary amount; a shift by the full WIDTH yields zero, covering s == 0.
  assign rs           = (SW + 1)'(WIDTH) - {1'b0, s};
  assign rol          = (a_i << s) | (a_i >> rs);
  assign ror          = (a_i >> s) | (a_i << rs);

  always_comb begin
    result_o = '0;
    flags_o  = '0;
    case (opcode_i)
      OP_ROL: begin
        result_o      = rol;
        flags_o.carry = (s != '0) && rol[0];
      end
      OP_ROR: begin
        result_o      = ror;
        flags_o.carry = (s != '0) && ror[WIDTH-1];
      end
      OP_MAX:  result_o = (a_i >= b_i) ? a_i : b_i;
      OP_MIN:  result_o = (a_i <= b_i) ? a_i : b_i;
      default: flags_o.illegal = 1'b1;
    endcase
    flags_o.zero = (result_o == '0);
  end

endmodule

// File: rtl/alu_rr_sched.sv
// Round-robin scheduler sharing one rotate/compare ALU between NUM_REQ
// requesters; one operation in flight, answered on a tagged response channel.
module alu_rr_sched
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned NUM_REQ = 4,
  localparam int unsigned ID_W   = $clog2(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [4*NUM_REQ-1:0]     req_opcode,
  input  logic [WIDTH*NUM_REQ-1:0] req_input1,
  input  logic [WIDTH*NUM_REQ-1:0] req_input2,
  input  logic [5*NUM_REQ-1:0]     req_shift,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [ID_W-1:0]          rsp_id,
  output logic [WIDTH-1:0]         rsp_result,
  output logic                     rsp_carry,
  output logic                     rsp_zero,
  output logic                     rsp_overflow,
  output logic                     rsp_illegal,
  output logic                     busy,
  output logic [15:0]              ops_done
);

  state_e           state_q, state_d;
  logic [ID_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0]  id_q, id_d;
  logic [3:0]       op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [4:0]       sh_q, sh_d;
  logic [ID_W-1:0]  rsp_id_q, rsp_id_d;
  logic [WIDTH-1:0] rsp_result_q, rsp_result_d;
  alu_flags_t       rsp_flags_q, rsp_flags_d;
  logic [15:0]      ops_done_q, ops_done_d;

  logic [NUM_REQ-1:0] ready_c;
  logic               found;
  logic [ID_W-1:0]    grant;
  logic [31:0]        nxt_ptr;
  logic [WIDTH-1:0]   alu_result;
  alu_flags_t         alu_flags;

  // Scan from ptr upward modulo NUM_REQ; returns {found, index}.
  function automatic logic [ID_W:0] rr_pick(input logic [NUM_REQ-1:0] valid,
                                            input logic [ID_W-1:0]    ptr);
    logic            hit;
    logic [ID_W-1:0] idx;
    logic [ID_W-1:0] cand;
    logic [31:0]     k;
    hit = 1'b0;
    idx = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      k    = (32'(ptr) + i) % NUM_REQ;
      cand = k[ID_W-1:0];
      if (!hit && valid[cand]) begin
        hit = 1'b1;
        idx = cand;
      end
    end
    return {hit, idx};
  endfunction

  alu_rot_cmp_core #(
    .WIDTH(WIDTH)
  ) u_core (
    .opcode_i(op_q),
    .a_i     (a_q),
    .b_i     (b_q),
    .shift_i (sh_q),
    .result_o(alu_result),
    .flags_o (alu_flags)
  );

  always_comb begin
    state_d      = state_q;
    rr_ptr_d     = rr_ptr_q;
    id_d         = id_q;
    op_d         = op_q;
    a_d          = a_q;
    b_d          = b_q;
    sh_d         = sh_q;
    rsp_id_d     = rsp_id_q;
    rsp_result_d = rsp_result_q;
    rsp_flags_d  = rsp_flags_q;
    ops_done_d   = ops_done_q;
    ready_c      = '0;
    {found, grant} = rr_pick(req_valid, rr_ptr_q);
    nxt_ptr      = (32'(grant) + 32'd1) % NUM_REQ;

    unique case (state_q)
      StIdle: begin
        if (found) begin
          ready_c[grant] = 1'b1;
          id_d     = grant;
          rr_ptr_d = nxt_ptr[ID_W-1:0];
          for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (32'(grant) == i) begin
              op_d = req_opcode[4*i +: 4];
              a_d  = req_input1[WIDTH*i +: WIDTH];
              b_d  = req_input2[WIDTH*i +: WIDTH];
              sh_d = req_shift[5*i +: 5];
            end
          end
          state_d = StExec;
        end
      end
      StExec: begin
        rsp_id_d     = id_q;
        rsp_result_d = alu_result;
        rsp_flags_d  = alu_flags;
        state_d      = StResp;
      end
      StResp: begin
        if (rsp_ready) begin
          ops_done_d = ops_done_q + 16'd1;
          state_d    = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      rr_ptr_q     <= '0;
      id_q         <= '0;
      op_q         <= '0;
      a_q          <= '0;
      b_q          <= '0;
      sh_q         <= '0;
      rsp_id_q     <= '0;
      rsp_result_q <= '0;
      rsp_flags_q  <= '0;
      ops_done_q   <= '0;
    end else begin
      state_q      <= state_d;
      rr_ptr_q     <= rr_ptr_d;
      id_q         <= id_d;
      op_q         <= op_d;
      a_q          <= a_d;
      b_q          <= b_d;
      sh_q         <= sh_d;
      rsp_id_q     <= rsp_id_d;
      rsp_result_q <= rsp_result_d;
      rsp_flags_q  <= rsp_flags_d;
      ops_done_q   <= ops_done_d;
    end
  end

  // Reset also masks the combinational grant while requesters are still valid.
  assign req_ready    = ready_c & {NUM_REQ{rst_n}};
  assign rsp_valid    = (state_q == StResp);
  assign busy         = (state_q != StIdle);
  assign rsp_id       = rsp_id_q;
  assign rsp_result   = rsp_result_q;
  assign rsp_carry    = rsp_flags_q.carry;
  assign rsp_zero     = rsp_flags_q.zero;
  assign rsp_overflow = rsp_flags_q.overflow;
  assign rsp_illegal  = rsp_flags_q.illegal;
  assign ops_done     = ops_done_q;

endmodule

// File: tb/tb_alu_rr_sched.sv
// Scoreboard bench for alu_rr_sched: directed scenarios plus random traffic
// checked against a behavioural model of arbitration and ALU results.
module tb_alu_rr_sched;

  localparam int W   = 8;
  localparam int N   = 4;
  localparam int IDW = 2;

  typedef struct packed {
    logic [IDW-1:0] id;
    logic [W-1:0]   result;
    logic           carry;
    logic           zero;
    logic           ovf;
    logic           illegal;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [N-1:0]   req_valid, req_ready;
  logic [4*N-1:0] req_opcode;
  logic [W*N-1:0] req_input1, req_input2;
  logic [5*N-1:0] req_shift;
  logic           rsp_valid, rsp_ready;
  logic [IDW-1:0] rsp_id;
  logic [W-1:0]   rsp_result;
  logic           rsp_carry, rsp_zero, rsp_overflow, rsp_illegal, busy;
  logic [15:0]    ops_done;

  logic       v  [N];
  logic [3:0] op [N];
  logic [W-1:0] a [N];
  logic [W-1:0] b [N];
  logic [4:0] sh [N];

  for (genvar g = 0; g < N; g++) begin : g_pack
    assign req_valid[g]          = v[g];
    assign req_opcode[4*g +: 4]  = op[g];
    assign req_input1[W*g +: W]  = a[g];
    assign req_input2[W*g +: W]  = b[g];
    assign req_shift[5*g +: 5]   = sh[g];
  end

  alu_rr_sched #(
    .WIDTH  (W),
    .NUM_REQ(N)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_opcode  (req_opcode),
    .req_input1  (req_input1),
    .req_input2  (req_input2),
    .req_shift   (req_shift),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_id      (rsp_id),
    .rsp_result  (rsp_result),
    .rsp_carry   (rsp_carry),
    .rsp_zero    (rsp_zero),
    .rsp_overflow(rsp_overflow),
    .rsp_illegal (rsp_illegal),
    .busy        (busy),
    .ops_done    (ops_done)
  );

  int          total = 0;
  int          bad = 0;
  int unsigned cyc = 0;
  int          mptr = 0;
  int          acc_cyc = 0;
  bit          lat_pending = 0;
  bit          acc_flag [N];
  int          gl_id [$];
  int          gl_cyc [$];
  exp_t        sb [$];
  int          hs_count = 0;
  logic [15:0] exp_ops = '0;
  exp_t        last_rsp;
  bit          holding = 0;
  logic [31:0] held;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    total++;
    bad++;
    $display("FAIL %s: timed out", name);
  endtask

  // Reference ALU: rotate one bit at a time s times, compare with plain operators.
  function automatic exp_t model(input logic [3:0] o, input logic [W-1:0] x,
                                 input logic [W-1:0] y, input logic [4:0] s5);
    exp_t e;
    int   s;
    e = '0;
    s = int'(s5) % W;
    case (o)
      4'd0: begin
        e.result = x;
        for (int k = 0; k < s; k++) e.result = {e.result[W-2:0], e.result[W-1]};
        e.carry = (s != 0) && e.result[0];
      end
      4'd1: begin
        e.result = x;
        for (int k = 0; k < s; k++) e.result = {e.result[0], e.result[W-1:1]};
        e.carry = (s != 0) && e.result[W-1];
      end
      4'd2:    e.result = (x >= y) ? x : y;
      4'd3:    e.result = (x <= y) ? x : y;
      default: e.illegal = 1'b1;
    endcase
    e.zero = (e.result == '0);
    return e;
  endfunction

  // Acceptance monitor: predicts the winner and pushes the expected response.
  always @(negedge clk) begin : acc_mon
    int   pick;
    exp_t e;
    if (rst_n) begin
      if (busy) begin
        check("ready_while_busy", 32'(req_ready), 32'd0);
      end else begin
        pick = -1;
        for (int k = 0; k < N; k++)
          if (pick < 0 && v[(mptr + k) % N]) pick = (mptr + k) % N;
        if (pick < 0) begin
          check("ready_no_valid", 32'(req_ready), 32'd0);
        end else begin
          check("grant", 32'(req_ready), 32'(1 << pick));
          e    = model(op[pick], a[pick], b[pick], sh[pick]);
          e.id = IDW'(pick);
          sb.push_back(e);
          mptr          = (pick + 1) % N;
          acc_flag[pick] = 1'b1;
          acc_cyc       = int'(cyc);
          lat_pending   = 1'b1;
          gl_id.push_back(pick);
          gl_cyc.push_back(int'(cyc));
        end
      end
    end
  end

  // Response monitor: latency, stability under backpressure, scoreboard pop.
  always @(negedge clk) begin : rsp_mon
    exp_t        e;
    logic [31:0] cur;
    if (rst_n && rsp_valid) begin
      cur = {18'd0, rsp_id, rsp_result, rsp_carry, rsp_zero, rsp_overflow, rsp_illegal};
      check("busy_in_resp", 32'(busy), 32'd1);
      if (lat_pending) begin
        check("latency", int'(cyc) - acc_cyc, 32'd2);
        lat_pending = 1'b0;
      end
      if (holding) check("rsp_stable", cur, held);
      if (rsp_ready) begin
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_rsp: got id %0d result %0h expected none", rsp_id, rsp_result);
        end else begin
          e = sb.pop_front();
          check("rsp_id", 32'(rsp_id), 32'(e.id));
          check("rsp_result", 32'(rsp_result), 32'(e.result));
          check("rsp_flags", {28'd0, rsp_carry, rsp_zero, rsp_overflow, rsp_illegal},
                {28'd0, e.carry, e.zero, e.ovf, e.illegal});
        end
        check("ops_done", 32'(ops_done), 32'(exp_ops));
        exp_ops  = exp_ops + 16'd1;
        last_rsp = {rsp_id, rsp_result, rsp_carry, rsp_zero, rsp_overflow, rsp_illegal};
        hs_count++;
        holding = 1'b0;
      end else begin
        holding = 1'b1;
        held    = cur;
      end
    end else begin
      holding = 1'b0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int i, input logic [3:0] o, input logic [W-1:0] x,
                      input logic [W-1:0] y, input logic [4:0] s);
    int t;
    op[i] = o; a[i] = x; b[i] = y; sh[i] = s; v[i] = 1'b1;
    t = 0;
    while (!acc_flag[i] && t < 50) begin
      tick();
      t++;
    end
    if (!acc_flag[i]) fail_now("send");
    acc_flag[i] = 1'b0;
    v[i] = 1'b0;
  endtask

  task automatic wait_rsp(input int n0);
    int t;
    t = 0;
    while (hs_count <= n0 && t < 50) begin
      tick();
      t++;
    end
    if (hs_count <= n0) fail_now("wait_rsp");
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while ((sb.size() != 0 || busy) && t < 200) begin
      tick();
      t++;
    end
    if (sb.size() != 0 || busy) fail_now("drain");
  endtask

  task automatic check_all_zero(input string name);
    check(name, {14'd0, rsp_valid, rsp_id, rsp_result, rsp_carry, rsp_zero, rsp_overflow,
                 rsp_illegal, busy, req_ready}, 32'd0);
    check({name, "_ops"}, 32'(ops_done), 32'd0);
  endtask

  task automatic new_payload(input int i);
    op[i] = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(4, 15)) : 4'($urandom_range(0, 3));
    a[i]  = W'($urandom);
    b[i]  = ($urandom_range(0, 7) == 0) ? a[i] : W'($urandom);
    sh[i] = 5'($urandom);
  endtask

  task automatic rand_step();
    for (int i = 0; i < N; i++) begin
      if (acc_flag[i]) begin
        acc_flag[i] = 1'b0;
        v[i] = 1'($urandom_range(0, 1));
        new_payload(i);
      end else if (!v[i]) begin
        if ($urandom_range(0, 2) == 0) begin
          v[i] = 1'b1;
          new_payload(i);
        end
      end else if ($urandom_range(0, 19) == 0) begin
        v[i] = 1'b0;
      end
    end
    rsp_ready = ($urandom_range(0, 3) != 0);
  endtask

  task automatic clear_acc();
    for (int i = 0; i < N; i++) acc_flag[i] = 1'b0;
  endtask

  initial begin
    int base;
    int t;
    int n0;
    for (int i = 0; i < N; i++) begin
      v[i] = 1'b1; op[i] = '0; a[i] = '0; b[i] = '0; sh[i] = '0; acc_flag[i] = 1'b0;
    end
    rsp_ready = 1'b0;
    #12;
    check_all_zero("reset_outputs");
    tick();
    for (int i = 0; i < N; i++) v[i] = 1'b0;
    rst_n = 1'b1;
    rsp_ready = 1'b1;

    // All requesters valid: grants rotate 0,1,2,3,0 three cycles apart.
    base = gl_id.size();
    for (int i = 0; i < N; i++) begin
      op[i] = (i % 2 == 0) ? 4'd3 : 4'd2; a[i] = 8'h05; b[i] = 8'hFA; v[i] = 1'b1;
    end
    t = 0;
    while (gl_id.size() < base + 5 && t < 100) begin
      tick();
      clear_acc();
      t++;
    end
    for (int i = 0; i < N; i++) v[i] = 1'b0;
    clear_acc();
    if (gl_id.size() < base + 5) fail_now("rr_grants");
    else begin
      for (int k = 0; k < 5; k++) begin
        check("rr_order", 32'(gl_id[base+k]), 32'(k % 4));
        if (k > 0) check("rr_gap", 32'(gl_cyc[base+k] - gl_cyc[base+k-1]), 32'd3);
      end
    end
    wait_idle();

    n0 = hs_count;
    send(0, 4'd0, 8'h81, 8'h00, 5'd1);
    wait_rsp(n0);
    check("rol_result", 32'(last_rsp.result), 32'h03);
    check("rol_carry", 32'(last_rsp.carry), 32'd1);
    check("rol_zero", 32'(last_rsp.zero), 32'd0);
    check("rol_ops_done", 32'(ops_done), 32'd6);

    n0 = hs_count;
    send(2, 4'd1, 8'h01, 8'h00, 5'd9);
    wait_rsp(n0);
    check("ror9_result", 32'(last_rsp.result), 32'h80);
    check("ror9_carry", 32'(last_rsp.carry), 32'd1);
    n0 = hs_count;
    send(2, 4'd1, 8'h01, 8'h00, 5'd8);
    wait_rsp(n0);
    check("ror8_result", 32'(last_rsp.result), 32'h01);
    check("ror8_carry", 32'(last_rsp.carry), 32'd0);

    // Backpressure: response held for 5 cycles.
    rsp_ready = 1'b0;
    send(1, 4'd2, 8'h33, 8'h44, 5'd0);
    tick();
    check("stall_enter", 32'(rsp_valid), 32'd1);
    repeat (5) begin
      tick();
      check("stall_valid", 32'(rsp_valid), 32'd1);
      check("stall_busy", 32'(busy), 32'd1);
      check("stall_ready", 32'(req_ready), 32'd0);
    end
    rsp_ready = 1'b1;
    tick();
    check("idle_after_hs", 32'(busy), 32'd0);
    check("stall_result", 32'(last_rsp.result), 32'h44);

    n0 = hs_count;
    send(3, 4'd7, 8'h5C, 8'hA3, 5'd4);
    wait_rsp(n0);
    check("illegal_result", 32'(last_rsp.result), 32'd0);
    check("illegal_flags", {28'd0, last_rsp.carry, last_rsp.zero, last_rsp.ovf, last_rsp.illegal},
          32'b0101);

    // Reset while an operation is in EXEC.
    send(1, 4'd0, 8'h5A, 8'h00, 5'd3);
    check("exec_busy", 32'(busy), 32'd1);
    check("exec_no_valid", 32'(rsp_valid), 32'd0);
    for (int i = 0; i < N; i++) v[i] = 1'b1;
    rst_n = 1'b0;
    #1;
    check_all_zero("reset_in_exec");
    sb.delete();
    mptr = 0;
    exp_ops = '0;
    lat_pending = 1'b0;
    clear_acc();
    tick();
    for (int i = 0; i < N; i++) v[i] = 1'b0;
    tick();
    rst_n = 1'b1;
    repeat (6) tick();
    check("no_rsp_after_reset", {30'd0, busy, rsp_valid}, 32'd0);
    base = gl_id.size();
    for (int i = 0; i < N; i++) v[i] = 1'b1;
    t = 0;
    while (gl_id.size() == base && t < 20) begin
      tick();
      t++;
    end
    for (int i = 0; i < N; i++) v[i] = 1'b0;
    clear_acc();
    if (gl_id.size() == base) fail_now("grant_after_reset");
    else check("first_after_reset", 32'(gl_id[base]), 32'd0);
    wait_idle();

    repeat (600) begin
      tick();
      rand_step();
    end
    for (int i = 0; i < N; i++) v[i] = 1'b0;
    rsp_ready = 1'b1;
    tick();
    clear_acc();
    wait_idle();
    check("sb_empty", 32'(sb.size()), 32'd0);
    check("final_ops_done", 32'(ops_done), 32'(exp_ops));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_rr_sched.md
Name: alu_rr_sched

Overview:
- Round-robin scheduler that shares one rotate/compare ALU datapath (ROL, ROR, MAX, MIN) between NUM_REQ requesters.
- Each requester submits opcode, operands and a shift amount over a valid/ready handshake. The block serialises the operations through the ALU.
- Results come back on one shared response channel, tagged with the requester ID, and carry the carry, zero and overflow flags.

Parameters:
- WIDTH, 8, operand/result width in bits (power of two, 8..32).
- NUM_REQ, 4, number of requesters (2..8).
- ID_W, $clog2(NUM_REQ), width of rsp_id (localparam).

Ports:
- clk  in  1  the only clock; all state changes on its rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  NUM_REQ  per-requester request valid.
- req_ready  out  NUM_REQ  per-requester accept; at most one bit high.
- req_opcode  in  4*NUM_REQ  flattened opcodes; requester i uses bits [4i+3:4i].
- req_input1  in  WIDTH*NUM_REQ  flattened operand A.
- req_input2  in  WIDTH*NUM_REQ  flattened operand B.
- req_shift  in  5*NUM_REQ  flattened shift amounts.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  response consumer ready.
- rsp_id  out  ID_W  index of the requester served.
- rsp_result  out  WIDTH  ALU result.
- rsp_carry  out  1  carry flag.
- rsp_zero  out  1  zero flag.
- rsp_overflow  out  1  overflow flag.
- rsp_illegal  out  1  opcode was not 0..3.
- busy  out  1  state != IDLE.
- ops_done  out  16  completed-response counter; wraps from 0xFFFF to 0.

Behaviour:
- Reset: rst_n low asynchronously forces state IDLE, rr_ptr=0, ops_done=0 and clears all captured operands. While in reset, rsp_valid, rsp_id, rsp_result, all flags, rsp_illegal, busy and req_ready are 0.
- FSM states are IDLE, EXEC and RESP.
- IDLE:
  - Arbiter scans req_valid starting at rr_ptr, upward modulo NUM_REQ. The first set bit is the winner g.
  - req_ready[g]=1 combinationally; every other req_ready bit is 0.
  - At the clock edge: capture the opcode, operands and shift of g; set rr_ptr=(g+1)%NUM_REQ; go to EXEC.
  - If no req_valid bit is set, stay in IDLE and leave rr_ptr unchanged.
- EXEC:
  - Captured operands drive the ALU sub-module.
  - At the edge: register result, flags, illegal and id into the rsp_* registers; go to RESP.
- RESP:
  - rsp_valid=1. rsp_* outputs hold stable until the handshake.
  - On rsp_valid&rsp_ready: increment ops_done and go to IDLE.
  - req_ready is all-zero in EXEC and RESP.
- Latency: if the request is accepted in cycle C, the state is EXEC in C+1 and rsp_valid is 1 in C+2. The earliest next acceptance is in the cycle after the response handshake, so the minimum interval is 3 cycles per operation.
- ALU rules:
  - Effective rotate amount s = shift mod WIDTH.
  - ROL(0): rotate input1 left by s. carry = result[0] if s!=0, else 0.
  - ROR(1): rotate input1 right by s. carry = result[WIDTH-1] if s!=0, else 0.
  - MAX(2) and MIN(3): unsigned comparison; on equality the result is input1. carry=0.
  - overflow is always 0.
  - zero = (result==0).
  - Opcodes 4..15: result 0, carry 0, zero 1, rsp_illegal 1. An illegal opcode is still granted and answered.
- Requester rules: a requester must hold its valid and payload stable until it sees ready. Payload changes after acceptance have no effect on the operation in flight.
- A requester that drops req_valid before it is granted is skipped with no side effects.
- Reset asserted in EXEC or RESP discards the in-flight operation; no response is produced after reset releases.

Decomposition:
- Shared package alu_pkg holds the opcode localparams OP_ROL=4'd0, OP_ROR=4'd1, OP_MAX=4'd2 and OP_MIN=4'd3, the state encoding (IDLE, EXEC, RESP) and the alu_flags_t struct {carry, zero, overflow, illegal}.
- One combinational sub-module, alu_rot_cmp_core, parameterised by WIDTH: opcode, a, b, shift in; result and alu_flags_t out.
- The round-robin pick is a function inside alu_rr_sched.

Test Plan:
- req_valid[0] only, ROL a=8'h81, shift=1 -> rsp_valid in C+2, rsp_id=0, result=8'h03, carry=1, zero=0, ops_done=1 after the handshake.
- req_valid[2], ROR a=8'h01, shift=9 (effective 1) -> result=8'h80, carry=1. Repeat with shift=8 -> result=8'h01, carry=0.
- All four requesters held valid with MAX and MIN ops (e.g. MIN 8'h05 vs 8'hFA -> 8'h05; MAX 8'h05 vs 8'hFA -> 8'hFA) -> grant order 0,1,2,3,0; each grant is spaced 3 cycles apart with rsp_ready=1.
- rsp_ready held low for 5 cycles in RESP -> rsp_* outputs stable, req_ready=0 and busy=1 throughout. Release -> IDLE the next cycle.
- Opcode 4'd7, any operands -> result=0, zero=1, carry=0, overflow=0, rsp_illegal=1.
- rst_n pulsed low during EXEC with req1 in flight -> all outputs 0 immediately and no response after release. With req_valid=4'b1111 afterwards, the first grant goes to requester 0.
